// File: rtl/dmc_param_cache.sv
// Parametrised direct-mapped cache (one word per line) between the CPU memory port and main memory.
// Write-through/no-allocate or write-back/write-allocate, variable-latency memory handshake, hit/miss counters.
module dmc_param_cache #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned INDEX_W    = 8,
  parameter int unsigned WRITE_BACK = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [DATA_W-1:0] cpu_din,
  output logic [DATA_W-1:0] cpu_dout,
  output logic              cpu_ready,
  output logic              cache_hit,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_din,
  output logic [DATA_W-1:0] mem_dout,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);
  localparam int unsigned TAG_W = ADDR_W - INDEX_W;
  localparam int unsigned LINES = 32'd1 << INDEX_W;
  localparam bit          WB    = (WRITE_BACK != 0);

  typedef enum logic [2:0] {S_IDLE, S_COMPARE, S_EVICT, S_FILL, S_MEM_WRITE} state_t;
  state_t state, state_d;

  logic [ADDR_W-1:0]  req_addr;
  logic [DATA_W-1:0]  req_din;
  logic               req_wr;
  logic               hit_q;
  logic [LINES-1:0]   valid, dirty;
  logic [TAG_W-1:0]   tag_ram  [LINES];
  logic [DATA_W-1:0]  data_ram [LINES];

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic               lookup_hit;

  assign idx        = req_addr[INDEX_W-1:0];
  assign tag        = req_addr[ADDR_W-1:INDEX_W];
  assign lookup_hit = valid[idx] && (tag_ram[idx] == tag);

  logic              accept, ready_d, hit_d, dout_ld, data_we, tag_we;
  logic              dirty_set, dirty_clr, hit_inc, miss_inc;
  logic [DATA_W-1:0] dout_val, data_wval, mem_dout_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic              mem_rd_d, mem_wr_d;

  always_ff @(posedge clk) begin
    if (clr) state <= S_IDLE;
    else     state <= state_d;
  end

  // Next state plus per-cycle control strobes for the datapath registers
  always_comb begin
    state_d    = state;
    accept     = 1'b0;
    ready_d    = 1'b0;
    hit_d      = 1'b0;
    dout_ld    = 1'b0;
    dout_val   = data_ram[idx];
    data_we    = 1'b0;
    data_wval  = req_din;
    tag_we     = 1'b0;
    dirty_set  = 1'b0;
    dirty_clr  = 1'b0;
    hit_inc    = 1'b0;
    miss_inc   = 1'b0;
    mem_addr_d = mem_addr;
    mem_dout_d = mem_dout;
    case (state)
      S_IDLE: begin
        if ((cpu_rd || cpu_wr) && !cpu_ready) begin
          accept  = 1'b1;
          state_d = S_COMPARE;
        end
      end
      S_COMPARE: begin
        hit_inc  = lookup_hit;
        miss_inc = !lookup_hit;
        if (lookup_hit && !req_wr) begin
          ready_d = 1'b1;
          hit_d   = 1'b1;
          dout_ld = 1'b1;
          state_d = S_IDLE;
        end else if (lookup_hit) begin
          data_we = 1'b1;
          if (WB) begin
            dirty_set = 1'b1;
            ready_d   = 1'b1;
            hit_d     = 1'b1;
            state_d   = S_IDLE;
          end else begin
            state_d = S_MEM_WRITE;
          end
        end else if (WB) begin
          if (valid[idx] && dirty[idx]) begin
            state_d = S_EVICT;
          end else if (!req_wr) begin
            state_d = S_FILL;
          end else begin
            data_we   = 1'b1;
            tag_we    = 1'b1;
            dirty_set = 1'b1;
            ready_d   = 1'b1;
            state_d   = S_IDLE;
          end
        end else begin
          state_d = req_wr ? S_MEM_WRITE : S_FILL;
        end
      end
      S_EVICT: begin
        if (mem_ready) begin
          dirty_clr = 1'b1;
          if (!req_wr) begin
            state_d = S_FILL;
          end else begin
            data_we   = 1'b1;
            tag_we    = 1'b1;
            dirty_set = 1'b1;
            ready_d   = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      S_FILL: begin
        if (mem_ready) begin
          data_we   = 1'b1;
          data_wval = mem_din;
          tag_we    = 1'b1;
          dirty_clr = 1'b1;
          dout_ld   = 1'b1;
          dout_val  = mem_din;
          ready_d   = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_MEM_WRITE: begin
        if (mem_ready) begin
          ready_d = 1'b1;
          hit_d   = hit_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Strobes follow the state being entered, so they drop the cycle after mem_ready
    mem_rd_d = (state_d == S_FILL);
    mem_wr_d = (state_d == S_EVICT) || (state_d == S_MEM_WRITE);
    case (state_d)
      S_EVICT: begin
        mem_addr_d = {tag_ram[idx], idx};
        mem_dout_d = data_ram[idx];
      end
      S_FILL:      mem_addr_d = req_addr;
      S_MEM_WRITE: begin
        mem_addr_d = req_addr;
        mem_dout_d = req_din;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      req_addr   <= '0;
      req_din    <= '0;
      req_wr     <= 1'b0;
      hit_q      <= 1'b0;
      valid      <= '0;
      dirty      <= '0;
      cpu_dout   <= '0;
      cpu_ready  <= 1'b0;
      cache_hit  <= 1'b0;
      mem_addr   <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_dout   <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (accept) begin
        req_addr <= cpu_addr;
        req_din  <= cpu_din;
        req_wr   <= cpu_wr;
      end
      if (state == S_COMPARE) hit_q <= lookup_hit;
      if (tag_we) valid[idx] <= 1'b1;
      if (dirty_set)      dirty[idx] <= 1'b1;
      else if (dirty_clr) dirty[idx] <= 1'b0;
      if (dout_ld) cpu_dout <= dout_val;
      cpu_ready <= ready_d;
      cache_hit <= hit_d;
      mem_addr  <= mem_addr_d;
      mem_dout  <= mem_dout_d;
      mem_rd    <= mem_rd_d;
      mem_wr    <= mem_wr_d;
      if (hit_inc && (hit_count != {CNT_W{1'b1}}))   hit_count  <= hit_count + CNT_W'(1);
      if (miss_inc && (miss_count != {CNT_W{1'b1}})) miss_count <= miss_count + CNT_W'(1);
    end
  end

  // Line storage is not reset; valid bits guard it
  always_ff @(posedge clk) begin
    if (!clr && data_we) data_ram[idx] <= data_wval;
    if (!clr && tag_we)  tag_ram[idx]  <= tag;
  end
endmodule

// File: tb/tb_dmc_param_cache.sv
// Bench for dmc_param_cache: a write-through instance (2-bit counters) and a write-back instance
// share one CPU driver and one variable-latency memory model, selected by sel.
module tb_dmc_param_cache;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr = 1'b1;
  logic        sel = 1'b0;
  logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
  logic [11:0] cpu_addr = '0;
  logic [15:0] cpu_din = '0;
  logic [15:0] mem_din = '0;
  logic        mem_ready = 1'b0;

  logic [15:0] dout_a, dout_b, mdout_a, mdout_b;
  logic        rdy_a, rdy_b, hit_a, hit_b, mrd_a, mrd_b, mwr_a, mwr_b;
  logic [11:0] maddr_a, maddr_b;
  logic [1:0]  hc_a, mc_a;
  logic [15:0] hc_b, mc_b;

  dmc_param_cache #(.WRITE_BACK(0), .CNT_W(2)) u_wt (
    .clk(clk), .clr(clr), .cpu_addr(cpu_addr), .cpu_rd(cpu_rd & ~sel), .cpu_wr(cpu_wr & ~sel),
    .cpu_din(cpu_din), .cpu_dout(dout_a), .cpu_ready(rdy_a), .cache_hit(hit_a),
    .mem_addr(maddr_a), .mem_rd(mrd_a), .mem_wr(mwr_a), .mem_din(mem_din), .mem_dout(mdout_a),
    .mem_ready(mem_ready & ~sel), .hit_count(hc_a), .miss_count(mc_a));

  dmc_param_cache #(.WRITE_BACK(1), .CNT_W(16)) u_wb (
    .clk(clk), .clr(clr), .cpu_addr(cpu_addr), .cpu_rd(cpu_rd & sel), .cpu_wr(cpu_wr & sel),
    .cpu_din(cpu_din), .cpu_dout(dout_b), .cpu_ready(rdy_b), .cache_hit(hit_b),
    .mem_addr(maddr_b), .mem_rd(mrd_b), .mem_wr(mwr_b), .mem_din(mem_din), .mem_dout(mdout_b),
    .mem_ready(mem_ready & sel), .hit_count(hc_b), .miss_count(mc_b));

  logic [15:0] dout, mdout, hc, mc;
  logic        rdy, hit, mrd, mwr;
  logic [11:0] maddr;
  assign dout  = sel ? dout_b  : dout_a;
  assign mdout = sel ? mdout_b : mdout_a;
  assign rdy   = sel ? rdy_b   : rdy_a;
  assign hit   = sel ? hit_b   : hit_a;
  assign mrd   = sel ? mrd_b   : mrd_a;
  assign mwr   = sel ? mwr_b   : mwr_a;
  assign maddr = sel ? maddr_b : maddr_a;
  assign hc    = sel ? hc_b    : {14'd0, hc_a};
  assign mc    = sel ? mc_b    : {14'd0, mc_a};

  // Memory model: unwritten words read as 0xD<addr>, except 0x123 which reads 0xBEEF
  int          lat = 1;
  int          scnt, rd_cyc, wr_cyc, overlap;
  logic [11:0] rd_addr = '0;
  logic [15:0] wmem [logic [11:0]];
  logic [27:0] wr_log [$];

  always @(negedge clk) begin
    if (mrd && mwr) overlap++;
    if (mrd || mwr) begin
      if (mem_ready) scnt = 0;
      scnt++;
      if (mrd) begin rd_cyc++; rd_addr = maddr; end
      if (mwr) wr_cyc++;
      mem_din   = wmem.exists(maddr) ? wmem[maddr] : ((maddr == 12'h123) ? 16'hBEEF : {4'hD, maddr});
      mem_ready = (scnt >= lat);
      if (mem_ready && mwr) begin
        wmem[maddr] = mdout;
        wr_log.push_back({maddr, mdout});
      end
    end else begin
      scnt      = 0;
      mem_ready = 1'b0;
    end
  end

  int          tests = 0, fails = 0;
  logic [16:0] exp_q [$];
  logic [16:0] e;
  logic [27:0] wl;
  logic [15:0] obs_dout;
  logic        obs_hit, obs_to;
  int          obs_edges, r0, w0;

  task automatic xfer(input logic rd, input logic wr, input logic [11:0] a, input logic [15:0] d);
    @(negedge clk);
    cpu_addr = a; cpu_din = d; cpu_rd = rd; cpu_wr = wr;
    obs_to = 1'b1; obs_edges = 0; obs_dout = 'x; obs_hit = 1'bx;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      obs_edges++;
      @(negedge clk);
      if (rdy) begin obs_dout = dout; obs_hit = hit; obs_to = 1'b0; break; end
    end
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    r0 = r0; w0 = w0;
  endtask

  task automatic do_reset();
    @(negedge clk); clr = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic pop_log();
    wl = (wr_log.size() != 0) ? wr_log.pop_front() : 28'hFFFFFFF;
  endtask

  task automatic test_reset();
    do_reset();
    for (int s = 0; s < 2; s++) begin
      sel = s[0]; #1;
      tests++;
      if ({rdy, hit, mrd, mwr, dout, maddr, mdout, hc, mc} !== '0) begin
        fails++;
        $display("FAIL reset_outputs sel=%0d: rdy=%b hit=%b rd=%b wr=%b dout=%h addr=%h mdout=%h hc=%0d mc=%0d, want all 0",
                 s, rdy, hit, mrd, mwr, dout, maddr, mdout, hc, mc);
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_read_miss();
    lat = 3; r0 = rd_cyc;
    exp_q.push_back({1'b0, 16'hBEEF});
    xfer(1'b1, 1'b0, 12'h123, 16'h0);
    e = exp_q.pop_front(); tests++;
    if (obs_to || {obs_hit, obs_dout} !== e) begin fails++;
      $display("FAIL read_miss_resp: timeout=%b hit=%b dout=%h, want %h", obs_to, obs_hit, obs_dout, e); end
    tests++;
    if (rd_cyc - r0 != 3 || rd_addr !== 12'h123) begin fails++;
      $display("FAIL read_miss_strobe: rd cycles=%0d addr=%h, want 3 cycles at 123", rd_cyc - r0, rd_addr); end
    tests++;
    if (mc !== 16'd1 || hc !== 16'd0) begin fails++;
      $display("FAIL read_miss_count: hit=%0d miss=%0d, want 0/1", hc, mc); end
  endtask

  task automatic test_read_hit();
    r0 = rd_cyc; w0 = wr_cyc;
    exp_q.push_back({1'b1, 16'hBEEF});
    xfer(1'b1, 1'b0, 12'h123, 16'h0);
    e = exp_q.pop_front(); tests++;
    if (obs_to || {obs_hit, obs_dout} !== e) begin fails++;
      $display("FAIL read_hit_resp: timeout=%b hit=%b dout=%h, want %h", obs_to, obs_hit, obs_dout, e); end
    tests++;
    if (obs_edges != 2) begin fails++;
      $display("FAIL read_hit_latency: %0d edges, want 2", obs_edges); end
    tests++;
    if (rd_cyc != r0 || wr_cyc != w0) begin fails++;
      $display("FAIL read_hit_no_mem: rd=%0d wr=%0d strobe cycles, want 0", rd_cyc - r0, wr_cyc - w0); end
    tests++;
    if (hc !== 16'd1) begin fails++;
      $display("FAIL read_hit_count: hit=%0d, want 1", hc); end
  endtask

  task automatic test_write_through();
    lat = 2; w0 = wr_cyc;
    exp_q.push_back({1'b0, 16'hBEEF});
    xfer(1'b0, 1'b1, 12'h040, 16'h00AA);
    e = exp_q.pop_front(); tests++;
    if (obs_to || {obs_hit, obs_dout} !== e) begin fails++;
      $display("FAIL wt_wmiss_resp: timeout=%b hit=%b dout=%h, want %h", obs_to, obs_hit, obs_dout, e); end
    pop_log(); tests++;
    if (wl !== {12'h040, 16'h00AA} || wr_cyc - w0 != 2) begin fails++;
      $display("FAIL wt_wmiss_mem: wrote %h in %0d cycles, want 04000aa in 2", wl, wr_cyc - w0); end
    exp_q.push_back({1'b0, 16'h00AA});
    xfer(1'b1, 1'b0, 12'h040, 16'h0);
    e = exp_q.pop_front(); tests++;
    if (obs_to || {obs_hit, obs_dout} !== e) begin fails++;
      $display("FAIL wt_no_alloc: timeout=%b hit=%b dout=%h, want %h", obs_to, obs_hit, obs_dout, e); end
    tests++;
    if (mc !== 16'd3) begin fails++;
      $display("FAIL wt_miss_count: miss=%0d, want 3", mc); end
    exp_q.push_back({1'b1, 16'h00AA});
    xfer(1'b0, 1'b1, 12'h123, 16'h2222);
    e = exp_q.pop_front(); tests++;
    if (obs_to || {obs_hit, obs_dout} !== e) begin fails++;
      $display("FAIL wt_whit_resp: timeout=%b hit=%b dout=%h, want %h", obs_to, obs_hit, obs_dout, e); end
    pop_log(); tests++;
    if (wl !== {12'h123, 16'h2222}) begin fails++;
      $display("FAIL wt_whit_mem: wrote %h, want 1232222", wl); end
    exp_q.push_back({1'b1, 16'h2222});
    xfer(1'b1, 1'b0, 12'h123, 16'h0);
    e = exp_q.pop_front(); tests++;
    if (obs_to || {obs_hit, obs_dout} !== e) begin fails++;
      $display("FAIL wt_whit_update: timeout=%b hit=%b dout=%h, want %h", obs_to, obs_hit, obs_dout, e); end
    tests++;
    if (hc !== 16'd3) begin fails++;
      $display("FAIL wt_hit_count: hit=%0d, want 3", hc); end
  endtask

  task automatic test_rd_wr_both();
    r0 = rd_cyc;
    exp_q.push_back({1'b0, 16'h2222});
    xfer(1'b1, 1'b1, 12'h010, 16'h5A5A);
    e = exp_q.pop_front(); tests++;
    if (obs_to || {obs_hit, obs_dout} !== e) begin fails++;
      $display("FAIL both_resp: timeout=%b hit=%b dout=%h, want %h", obs_to, obs_hit, obs_dout, e); end
    pop_log(); tests++;
    if (wl !== {12'h010, 16'h5A5A} || rd_cyc != r0) begin fails++;
      $display("FAIL both_is_write: wrote %h rd cycles=%0d, want 0105a5a and 0", wl, rd_cyc - r0); end
    tests++;
    if (mc !== 16'd3) begin fails++;
      $display("FAIL miss_saturate: miss=%0d, want 3", mc); end
  endtask

  task automatic test_saturate();
    do_reset();
    sel = 1'b0; lat = 1; r0 = rd_cyc;
    exp_q.push_back({1'b0, 16'h2222});
    xfer(1'b1, 1'b0, 12'h123, 16'h0);
    e = exp_q.pop_front(); tests++;
    if (obs_to || {obs_hit, obs_dout} !== e || rd_cyc - r0 != 1) begin fails++;
      $display("FAIL lat1_fill: timeout=%b hit=%b dout=%h rd cycles=%0d, want %h in 1", obs_to, obs_hit, obs_dout, rd_cyc - r0, e); end
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back({1'b1, 16'h2222});
      xfer(1'b1, 1'b0, 12'h123, 16'h0);
      e = exp_q.pop_front(); tests++;
      if (obs_to || {obs_hit, obs_dout} !== e) begin fails++;
        $display("FAIL sat_hit%0d: timeout=%b hit=%b dout=%h, want %h", k, obs_to, obs_hit, obs_dout, e); end
    end
    tests++;
    if (hc !== 16'd3 || mc !== 16'd1) begin fails++;
      $display("FAIL hit_saturate: hit=%0d miss=%0d, want 3/1", hc, mc); end
  endtask

  task automatic test_write_back();
    sel = 1'b1; lat = 2; r0 = rd_cyc; w0 = wr_cyc;
    exp_q.push_back({1'b0, 16'h0000});
    xfer(1'b0, 1'b1, 12'h123, 16'h1111);
    e = exp_q.pop_front(); tests++;
    if (obs_to || {obs_hit, obs_dout} !== e || rd_cyc != r0 || wr_cyc != w0) begin fails++;
      $display("FAIL wb_alloc_write: timeout=%b hit=%b dout=%h strobes=%0d, want %h and none",
               obs_to, obs_hit, obs_dout, rd_cyc - r0 + wr_cyc - w0, e); end
    r0 = rd_cyc;
    exp_q.push_back({1'b0, 16'hD523});
    xfer(1'b1, 1'b0, 12'h523, 16'h0);
    e = exp_q.pop_front(); tests++;
    if (obs_to || {obs_hit, obs_dout} !== e) begin fails++;
      $display("FAIL wb_evict_fill_resp: timeout=%b hit=%b dout=%h, want %h", obs_to, obs_hit, obs_dout, e); end
    pop_log(); tests++;
    if (wl !== {12'h123, 16'h1111} || rd_addr !== 12'h523 || rd_cyc - r0 != 2) begin fails++;
      $display("FAIL wb_evict_mem: wrote %h, fill addr %h in %0d cycles, want 1231111 then 523 in 2", wl, rd_addr, rd_cyc - r0); end
    w0 = wr_cyc;
    exp_q.push_back({1'b1, 16'hD523});
    xfer(1'b0, 1'b1, 12'h523, 16'h3333);
    e = exp_q.pop_front(); tests++;
    if (obs_to || {obs_hit, obs_dout} !== e || wr_cyc != w0) begin fails++;
      $display("FAIL wb_write_hit: timeout=%b hit=%b dout=%h wr cycles=%0d, want %h and 0", obs_to, obs_hit, obs_dout, wr_cyc - w0, e); end
    r0 = rd_cyc;
    exp_q.push_back({1'b0, 16'hD523});
    xfer(1'b0, 1'b1, 12'h923, 16'h4444);
    e = exp_q.pop_front(); tests++;
    if (obs_to || {obs_hit, obs_dout} !== e) begin fails++;
      $display("FAIL wb_dirty_wmiss_resp: timeout=%b hit=%b dout=%h, want %h", obs_to, obs_hit, obs_dout, e); end
    pop_log(); tests++;
    if (wl !== {12'h523, 16'h3333} || rd_cyc != r0) begin fails++;
      $display("FAIL wb_dirty_wmiss_mem: wrote %h rd cycles=%0d, want 5233333 and 0", wl, rd_cyc - r0); end
    exp_q.push_back({1'b1, 16'h4444});
    xfer(1'b1, 1'b0, 12'h923, 16'h0);
    e = exp_q.pop_front(); tests++;
    if (obs_to || {obs_hit, obs_dout} !== e) begin fails++;
      $display("FAIL wb_installed_read: timeout=%b hit=%b dout=%h, want %h", obs_to, obs_hit, obs_dout, e); end
    tests++;
    if (hc !== 16'd2 || mc !== 16'd3) begin fails++;
      $display("FAIL wb_counts: hit=%0d miss=%0d, want 2/3", hc, mc); end
    tests++;
    if (overlap != 0) begin fails++;
      $display("FAIL strobe_overlap: %0d cycles with mem_rd and mem_wr both high, want 0", overlap); end
  endtask

  task automatic test_clr_abort();
    bit seen;
    sel = 1'b0; lat = 20; seen = 1'b0;
    @(negedge clk);
    cpu_addr = 12'h777; cpu_rd = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mrd) begin seen = 1'b1; break; end
    end
    cpu_rd = 1'b0; clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    tests++;
    if (!seen || mrd !== 1'b0 || rdy !== 1'b0 || hc !== 16'd0 || mc !== 16'd0) begin fails++;
      $display("FAIL clr_abort: fill seen=%b rd=%b rdy=%b hit=%0d miss=%0d, want 1/0/0/0/0", seen, mrd, rdy, hc, mc); end
    lat = 1;
    exp_q.push_back({1'b0, 16'hD777});
    xfer(1'b1, 1'b0, 12'h777, 16'h0);
    e = exp_q.pop_front(); tests++;
    if (obs_to || {obs_hit, obs_dout} !== e) begin fails++;
      $display("FAIL clr_then_miss: timeout=%b hit=%b dout=%h, want %h", obs_to, obs_hit, obs_dout, e); end
    tests++;
    if (mc !== 16'd1) begin fails++;
      $display("FAIL clr_miss_count: miss=%0d, want 1", mc); end
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write_through();
    test_rd_wr_both();
    test_saturate();
    test_write_back();
    test_clr_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end
endmodule

// File: doc/dmc_param_cache.md
Name: dmc_param_cache

Overview:
- Parametrised direct-mapped cache between the Mano CPU and main memory; successor to the 256x16 direct-mapped cache.
- One word per line. Selectable write-through or write-back policy. Variable-latency memory handshake. Hit/miss statistics counters.
- Sits between the CPU memory port and the memory model; the CPU stalls on cpu_ready.

Parameters:
- ADDR_W, 12: address width (legal range 2..16).
- DATA_W, 16: data word width.
- INDEX_W, 8: index bits; line count = 2**INDEX_W. Legal range 1..ADDR_W-1; tag width TAG_W = ADDR_W-INDEX_W.
- WRITE_BACK, 0: 0 = write-through, no-write-allocate; 1 = write-back, write-allocate.
- CNT_W, 16: width of the hit and miss statistics counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- clr  in  1  reset; synchronous, active-high.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_rd  in  1  CPU read request; held until cpu_ready.
- cpu_wr  in  1  CPU write request; held until cpu_ready.
- cpu_din  in  DATA_W  write data, CPU to cache.
- cpu_dout  out  DATA_W  read data, cache to CPU; valid while cpu_ready=1.
- cpu_ready  out  1  one-cycle completion pulse.
- cache_hit  out  1  high together with cpu_ready when the access hit.
- mem_addr  out  ADDR_W  memory address.
- mem_rd  out  1  memory read strobe; level, held until mem_ready.
- mem_wr  out  1  memory write strobe; level, held until mem_ready.
- mem_din  in  DATA_W  read data, memory to cache.
- mem_dout  out  DATA_W  write data, cache to memory.
- mem_ready  in  1  memory completion; sampled only while mem_rd or mem_wr is high.
- hit_count  out  CNT_W  saturating count of hits.
- miss_count  out  CNT_W  saturating count of misses.

Behaviour:
- Reset (clr=1 at an edge): all valid and dirty bits clear, state = IDLE, every output 0. clr takes effect mid-transaction: the request is aborted, mem_rd/mem_wr are low from the next cycle, and any in-flight memory data is discarded. Data/tag arrays are not cleared.
- Address split: index = cpu_addr[INDEX_W-1:0], tag = cpu_addr[ADDR_W-1:INDEX_W].
- IDLE:
  - Accepts a request when (cpu_rd|cpu_wr)=1 and cpu_ready=0. The cpu_ready=0 condition gives a one-cycle turnaround, so a still-held request is not re-accepted.
  - Latches addr, din and op, then goes to COMPARE. If cpu_rd and cpu_wr are both high, the access is a write.
- COMPARE: hit = valid[idx] & (tag_ram[idx]==tag).
  - Read hit: cpu_dout <= data[idx]; cpu_ready=1, cache_hit=1; to IDLE. Total latency is 2 edges after acceptance.
  - Write hit, WB=1: write data[idx], set dirty; cpu_ready=1, cache_hit=1; to IDLE.
  - Write hit, WB=0: write data[idx]; to MEM_WRITE.
  - Miss, WB=1, valid & dirty victim: to EVICT. cache_hit=0 on the final ready.
  - Miss, WB=1, clean or invalid victim: a read goes to FILL; a write installs the line (data, tag, valid=1, dirty=1) and completes.
  - Miss, WB=0: a read goes to FILL; a write goes to MEM_WRITE with no allocation.
- EVICT: mem_wr=1, mem_addr={tag_ram[idx],idx}, mem_dout=data[idx].
  - On mem_ready, drop mem_wr and clear dirty.
  - Then a read goes to FILL; a write installs the line as above, sets dirty, and completes.
- FILL: mem_rd=1, mem_addr=req addr.
  - On mem_ready: data[idx] <= mem_din, tag written, valid=1, dirty=0, cpu_dout <= mem_din, cpu_ready=1, cache_hit=0; to IDLE.
- MEM_WRITE (WB=0 only): mem_wr=1, mem_addr=req addr, mem_dout=req din.
  - On mem_ready: cpu_ready=1, cache_hit = the hit result captured in COMPARE; to IDLE.
- Memory handshake: mem_rd and mem_wr are never high together, and each drops in the cycle after mem_ready is sampled. mem_addr and mem_dout are stable while a strobe is high. mem_ready=1 in the first strobe cycle is legal, giving 1-cycle memory latency.
- Counters: hit_count or miss_count increments once per access, in COMPARE. Each saturates at all-ones; no wrap.
- cpu_ready and cache_hit are registered one-cycle pulses. cpu_dout holds its value until the next read completes.

Test Plan:
- Reset, then read addr 0x123 with memory returning 0xBEEF after 3 cycles -> mem_rd held 3 cycles with mem_addr=0x123; cpu_ready pulse, cpu_dout=0xBEEF, cache_hit=0, miss_count=1.
- Re-read 0x123 -> cpu_ready 2 edges after acceptance, cache_hit=1, dout=0xBEEF, no memory strobe, hit_count=1.
- WB=1: write 0x123=0x1111, then read 0x523 (same index, tag differs) -> EVICT writes 0x1111 to 0x123, then FILL from 0x523; mem_rd/mem_wr never overlap.
- WB=0: write-miss to 0x040=0x00AA -> mem_wr with data 0x00AA and cache_hit=0; a following read of 0x040 misses (no allocate).
- Assert clr during FILL while mem_ready is low -> mem_rd low next cycle, a read of the same address then misses, counters 0.
- cpu_rd=cpu_wr=1 on 0x010 -> treated as a write; CNT_W=2 with 5 hits -> hit_count saturates at 3.
